// File: rtl/sim_output_checker.sv
// rtl/sim_output_checker.sv - simulation-side checker for the SoC output-device port
//
// Accepts 5-bit frames from the SoC over a four-phase rdy/ack handshake and
// compares each one, in arrival order, with a preloaded expected-frame image.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   exp_wr_en/data      append one expected frame (ignored when full or locked)
//   output_rdy/data     SoC frame valid / frame value
//   output_ack          registered four-phase acknowledge
//   exp_count           expected frames loaded
//   frame_cnt           frames captured (saturating)
//   mismatch_cnt        frames differing from expected (saturating)
//   err_valid, first_err_idx/got/exp   first-mismatch record
//   extra_frame         sticky: frame beyond the loaded image
//   timeout_err         sticky: ack timeout or rdy dropped before ack
//   done                image loaded and every expected frame received
module sim_output_checker #(
  parameter int DEPTH     = 256,
  parameter int AW        = 8,
  parameter int ACK_DELAY = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          exp_wr_en,
  input  logic [4:0]    exp_wr_data,
  input  logic          output_rdy,
  input  logic [4:0]    output_data,
  output logic          output_ack,
  output logic [AW:0]   exp_count,
  output logic [AW:0]   frame_cnt,
  output logic [15:0]   mismatch_cnt,
  output logic          err_valid,
  output logic [AW:0]   first_err_idx,
  output logic [4:0]    first_err_got,
  output logic [4:0]    first_err_exp,
  output logic          extra_frame,
  output logic          timeout_err,
  output logic          done
);

  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DELAY, ACK, HALT} state_t;

  state_t        state;
  logic [4:0]    mem [DEPTH];
  logic          locked;
  logic [15:0]   dly_cnt;
  logic [TW-1:0] to_cnt;

  logic          capture;
  logic          wr_ok;
  logic          in_range;
  logic [4:0]    exp_val;

  assign capture  = (state == IDLE) && output_rdy;
  // The capture cycle itself locks the image, so a write landing on it is dropped.
  assign wr_ok    = exp_wr_en && !locked && !capture && (exp_count < CW'(DEPTH));
  assign in_range = frame_cnt < exp_count;
  assign exp_val  = mem[frame_cnt[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[exp_count[AW-1:0]] <= exp_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      locked        <= 1'b0;
      dly_cnt       <= '0;
      to_cnt        <= '0;
      output_ack    <= 1'b0;
      exp_count     <= '0;
      frame_cnt     <= '0;
      mismatch_cnt  <= '0;
      err_valid     <= 1'b0;
      first_err_idx <= '0;
      first_err_got <= '0;
      first_err_exp <= '0;
      extra_frame   <= 1'b0;
      timeout_err   <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= (exp_count != '0) && (frame_cnt == exp_count);

      if (wr_ok) begin
        exp_count <= exp_count + 1'b1;
      end

      case (state)
        IDLE: begin
          output_ack <= 1'b0;
          if (output_rdy) begin
            locked <= 1'b1;
            if (frame_cnt != '1) begin
              frame_cnt <= frame_cnt + 1'b1;
            end
            if (in_range) begin
              if (output_data != exp_val) begin
                if (mismatch_cnt != 16'hFFFF) begin
                  mismatch_cnt <= mismatch_cnt + 16'd1;
                end
                if (!err_valid) begin
                  err_valid     <= 1'b1;
                  first_err_idx <= frame_cnt;
                  first_err_got <= output_data;
                  first_err_exp <= exp_val;
                end
              end
            end else begin
              extra_frame <= 1'b1;
            end
            dly_cnt <= '0;
            to_cnt  <= '0;
            state   <= (ACK_DELAY == 0) ? ACK : DELAY;
          end
        end

        DELAY: begin
          if (!output_rdy) begin
            // rdy withdrawn before it was acknowledged: protocol violation
            timeout_err <= 1'b1;
            state       <= HALT;
          end else if (dly_cnt == 16'(ACK_DELAY - 1)) begin
            state <= ACK;
          end else begin
            dly_cnt <= dly_cnt + 16'd1;
          end
        end

        ACK: begin
          if (!output_rdy) begin
            output_ack <= 1'b0;
            state      <= IDLE;
          end else if (!output_ack) begin
            // first ACK cycle: raise ack; timeout counts cycles with ack high
            output_ack <= 1'b1;
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            output_ack  <= 1'b0;
            state       <= HALT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        HALT: begin
          output_ack <= 1'b0;
        end

        default: begin
          output_ack <= 1'b0;
          state      <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sim_output_checker.sv
// tb/tb_sim_output_checker.sv - self-checking bench for sim_output_checker
module tb_sim_output_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: DEPTH=16, ACK_DELAY=2, TIMEOUT=16
  logic        a_reset, a_wr_en, a_rdy, a_ack;
  logic [4:0]  a_wr_data, a_data;
  logic [4:0]  a_exp_count, a_frame_cnt, a_first_idx;
  logic [15:0] a_mm;
  logic        a_ev, a_extra, a_to, a_done;
  logic [4:0]  a_got, a_exp;

  sim_output_checker #(.DEPTH(16), .AW(4), .ACK_DELAY(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset(a_reset), .exp_wr_en(a_wr_en), .exp_wr_data(a_wr_data),
    .output_rdy(a_rdy), .output_data(a_data), .output_ack(a_ack),
    .exp_count(a_exp_count), .frame_cnt(a_frame_cnt), .mismatch_cnt(a_mm),
    .err_valid(a_ev), .first_err_idx(a_first_idx), .first_err_got(a_got),
    .first_err_exp(a_exp), .extra_frame(a_extra), .timeout_err(a_to), .done(a_done)
  );

  // DUT B: default geometry, ACK_DELAY=0
  logic        b_reset, b_wr_en, b_rdy, b_ack;
  logic [4:0]  b_wr_data, b_data;
  logic [8:0]  b_exp_count, b_frame_cnt, b_first_idx;
  logic [15:0] b_mm;
  logic        b_ev, b_extra, b_to, b_done;
  logic [4:0]  b_got, b_exp;

  sim_output_checker #(.DEPTH(256), .AW(8), .ACK_DELAY(0), .TIMEOUT(1024)) dut0 (
    .clk(clk), .reset(b_reset), .exp_wr_en(b_wr_en), .exp_wr_data(b_wr_data),
    .output_rdy(b_rdy), .output_data(b_data), .output_ack(b_ack),
    .exp_count(b_exp_count), .frame_cnt(b_frame_cnt), .mismatch_cnt(b_mm),
    .err_valid(b_ev), .first_err_idx(b_first_idx), .first_err_got(b_got),
    .first_err_exp(b_exp), .extra_frame(b_extra), .timeout_err(b_to), .done(b_done)
  );

  typedef struct {
    int             nl;
    logic [0:3][4:0] ld;
    int             ns;
    logic [0:3][4:0] sd;
    int fc, mm, ev, idx, got, ex, extra, done;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic a_do_reset();
    a_reset = 1'b1; a_rdy = 1'b0; a_wr_en = 1'b0;
    repeat (2) @(negedge clk);
    a_reset = 1'b0;
  endtask

  task automatic a_load(input logic [4:0] v);
    a_wr_en = 1'b1; a_wr_data = v;
    @(negedge clk);
    a_wr_en = 1'b0;
  endtask

  task automatic a_send(input logic [4:0] v, input int exp_lat);
    int lat;
    int n;
    a_rdy = 1'b1; a_data = v; lat = 0;
    while (!a_ack && lat < 64) begin @(negedge clk); lat++; end
    check("ack_latency", lat, exp_lat);
    a_rdy = 1'b0; n = 0;
    while (a_ack && n < 64) begin @(negedge clk); n++; end
    check("ack_fall", int'(a_ack), 0);
  endtask

  task automatic run_row(input int r);
    for (int i = 0; i < vecs[r].nl; i++) a_load(vecs[r].ld[i]);
    for (int i = 0; i < vecs[r].ns; i++) a_send(vecs[r].sd[i], 4);
    repeat (2) @(negedge clk);
    check($sformatf("row%0d_exp_count", r), int'(a_exp_count), vecs[r].nl);
    check($sformatf("row%0d_frame_cnt", r), int'(a_frame_cnt), vecs[r].fc);
    check($sformatf("row%0d_mismatch", r), int'(a_mm), vecs[r].mm);
    check($sformatf("row%0d_err_valid", r), int'(a_ev), vecs[r].ev);
    check($sformatf("row%0d_first_idx", r), int'(a_first_idx), vecs[r].idx);
    check($sformatf("row%0d_first_got", r), int'(a_got), vecs[r].got);
    check($sformatf("row%0d_first_exp", r), int'(a_exp), vecs[r].ex);
    check($sformatf("row%0d_extra", r), int'(a_extra), vecs[r].extra);
    check($sformatf("row%0d_done", r), int'(a_done), vecs[r].done);
    check($sformatf("row%0d_timeout", r), int'(a_to), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [4:0] q[$];
    logic [4:0] v;
    int n_load, n_send, m_mm, m_ev, m_idx, m_got, m_exp, m_extra;

    a_reset = 1'b1; a_wr_en = 1'b0; a_wr_data = '0; a_rdy = 1'b0; a_data = '0;
    b_reset = 1'b1; b_wr_en = 1'b0; b_wr_data = '0; b_rdy = 1'b0; b_data = '0;

    vecs[0] = '{4, {5'h01, 5'h1F, 5'h00, 5'h0A}, 4, {5'h01, 5'h1F, 5'h00, 5'h0A},
                4, 0, 0, 0, 0, 0, 0, 1};
    vecs[1] = '{3, {5'h03, 5'h04, 5'h05, 5'h00}, 3, {5'h03, 5'h06, 5'h07, 5'h00},
                3, 2, 1, 1, 6, 4, 0, 1};
    vecs[2] = '{2, {5'h11, 5'h12, 5'h00, 5'h00}, 3, {5'h11, 5'h12, 5'h13, 5'h00},
                3, 0, 0, 0, 0, 0, 1, 0};
    vecs[3] = '{0, {5'h00, 5'h00, 5'h00, 5'h00}, 1, {5'h07, 5'h00, 5'h00, 5'h00},
                1, 0, 0, 0, 0, 0, 1, 0};

    repeat (3) @(negedge clk);
    a_reset = 1'b0; b_reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_ack", int'(a_ack), 0);
    check("rst_exp_count", int'(a_exp_count), 0);
    check("rst_frame_cnt", int'(a_frame_cnt), 0);
    check("rst_mismatch", int'(a_mm), 0);
    check("rst_flags", int'({a_ev, a_extra, a_to, a_done}), 0);

    // Table-driven scenarios
    for (int r = 0; r < 4; r++) begin
      a_do_reset();
      run_row(r);
    end

    // Depth saturation: DEPTH+1 writes
    a_do_reset();
    for (int i = 0; i < 17; i++) a_load(5'(i));
    @(negedge clk);
    check("depth_sat", int'(a_exp_count), 16);

    // Write coinciding with first capture is dropped; later writes are locked out
    a_do_reset();
    a_load(5'h01); a_load(5'h02);
    a_rdy = 1'b1; a_data = 5'h01; a_wr_en = 1'b1; a_wr_data = 5'h1E;
    @(negedge clk);
    a_wr_en = 1'b0;
    n = 0;
    while (!a_ack && n < 64) begin @(negedge clk); n++; end
    a_rdy = 1'b0;
    @(negedge clk);
    check("lock_same_cycle", int'(a_exp_count), 2);
    a_load(5'h03);
    @(negedge clk);
    check("lock_later", int'(a_exp_count), 2);
    a_send(5'h02, 4);
    repeat (2) @(negedge clk);
    check("lock_done", int'(a_done), 1);
    check("lock_mm", int'(a_mm), 0);

    // Ack timeout: rdy held high forever
    a_do_reset();
    a_load(5'h02);
    a_rdy = 1'b1; a_data = 5'h02;
    n = 0;
    while (!a_ack && n < 64) begin @(negedge clk); n++; end
    n = 0;
    while (a_ack && n < 100) begin n++; @(negedge clk); end
    check("timeout_ack_cycles", n, 16);
    check("timeout_err", int'(a_to), 1);
    check("timeout_ack_low", int'(a_ack), 0);
    a_rdy = 1'b0; @(negedge clk);
    a_rdy = 1'b1; repeat (3) @(negedge clk);
    a_rdy = 1'b0; repeat (2) @(negedge clk);
    check("halt_no_capture", int'(a_frame_cnt), 1);
    check("halt_ack", int'(a_ack), 0);

    // rdy withdrawn during DELAY
    a_do_reset();
    a_rdy = 1'b1; a_data = 5'h05;
    @(negedge clk);
    a_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("delay_drop_err", int'(a_to), 1);
    check("delay_drop_fc", int'(a_frame_cnt), 1);
    check("delay_drop_extra", int'(a_extra), 1);

    // Reset while ack is high, then rerun the clean scenario
    a_do_reset();
    for (int i = 0; i < 4; i++) a_load(vecs[0].ld[i]);
    a_rdy = 1'b1; a_data = 5'h01;
    n = 0;
    while (!a_ack && n < 64) begin @(negedge clk); n++; end
    check("midack_ack_high", int'(a_ack), 1);
    a_reset = 1'b1;
    @(negedge clk);
    check("midack_ack", int'(a_ack), 0);
    check("midack_fc", int'(a_frame_cnt), 0);
    check("midack_ec", int'(a_exp_count), 0);
    a_reset = 1'b0; a_rdy = 1'b0;
    @(negedge clk);
    run_row(0);

    // Randomized runs against a queue-based reference model
    for (int it = 0; it < 20; it++) begin
      a_do_reset();
      q.delete();
      n_load = $urandom_range(1, 18);
      for (int i = 0; i < n_load; i++) begin
        v = 5'($urandom_range(0, 31));
        a_load(v);
        if (q.size() < 16) q.push_back(v);
      end
      n_send = $urandom_range(0, q.size() + 2);
      m_mm = 0; m_ev = 0; m_idx = 0; m_got = 0; m_exp = 0; m_extra = 0;
      for (int i = 0; i < n_send; i++) begin
        if (i >= q.size() || $urandom_range(0, 3) == 0) v = 5'($urandom_range(0, 31));
        else v = q[i];
        if (i < q.size()) begin
          if (v != q[i]) begin
            m_mm++;
            if (m_ev == 0) begin m_ev = 1; m_idx = i; m_got = int'(v); m_exp = int'(q[i]); end
          end
        end else begin
          m_extra = 1;
        end
        a_send(v, 4);
      end
      repeat (2) @(negedge clk);
      check($sformatf("rnd%0d_ec", it), int'(a_exp_count), q.size());
      check($sformatf("rnd%0d_fc", it), int'(a_frame_cnt), n_send);
      check($sformatf("rnd%0d_mm", it), int'(a_mm), m_mm);
      check($sformatf("rnd%0d_ev", it), int'(a_ev), m_ev);
      check($sformatf("rnd%0d_idx", it), int'(a_first_idx), m_idx);
      check($sformatf("rnd%0d_got", it), int'(a_got), m_got);
      check($sformatf("rnd%0d_exp", it), int'(a_exp), m_exp);
      check($sformatf("rnd%0d_extra", it), int'(a_extra), m_extra);
      check($sformatf("rnd%0d_done", it), int'(a_done), int'(q.size() != 0 && n_send == q.size()));
    end

    // ACK_DELAY = 0 instance: ack two cycles after rdy
    b_wr_en = 1'b1; b_wr_data = 5'h05;
    @(negedge clk);
    b_wr_en = 1'b0;
    b_rdy = 1'b1; b_data = 5'h05;
    n = 0;
    while (!b_ack && n < 64) begin @(negedge clk); n++; end
    check("d0_latency", n, 2);
    b_rdy = 1'b0;
    n = 0;
    while (b_ack && n < 64) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check("d0_fc", int'(b_frame_cnt), 1);
    check("d0_mm", int'(b_mm), 0);
    check("d0_done", int'(b_done), 1);
    check("d0_flags", int'({b_ev, b_extra, b_to}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
